// File: rtl/wm_pkg.sv
// Shared washing-machine controller encoding and phase-duration helpers.
package wm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READY = 3'd1;
  localparam logic [2:0] ST_SOAK  = 3'd2;
  localparam logic [2:0] ST_WASH  = 3'd3;
  localparam logic [2:0] ST_RINSE = 3'd4;
  localparam logic [2:0] ST_SPIN  = 3'd5;
  localparam logic [2:0] ST_PAUSE = 3'd6;
  localparam logic [2:0] ST_FAULT = 3'd7;

  function automatic logic is_timed(input logic [2:0] st);
    return (st >= ST_SOAK) && (st <= ST_SPIN);
  endfunction

  // Durations come in as arguments so each timer instance keeps its own parameter set.
  function automatic int unsigned phase_dur(input logic [2:0] st,
                                            input int unsigned soak_t,
                                            input int unsigned wash_t,
                                            input int unsigned rinse_t,
                                            input int unsigned spin_t);
    case (st)
      ST_SOAK:  return soak_t;
      ST_WASH:  return wash_t;
      ST_RINSE: return rinse_t;
      ST_SPIN:  return spin_t;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// Controller <-> phase timer link: controller state and lid in, timeout and status back.
interface wash_phase_timer_if #(parameter int CNT_W = 8);

  logic [2:0]       state;
  logic             sig_Lid_Closed;
  logic             sig_Time_Out;
  logic [CNT_W-1:0] remaining;
  logic             phase_active;

  modport master (output state, sig_Lid_Closed,
                  input  sig_Time_Out, remaining, phase_active);
  modport slave  (input  state, sig_Lid_Closed,
                  output sig_Time_Out, remaining, phase_active);

endinterface

// File: rtl/wm_prescaler.sv
// Purpose: divides enabled cycles by TICK_DIV into a single-cycle tick.
// Latency: tick is combinational on the TICK_DIV-th enabled cycle since clear.
// Backpressure: none; en low holds the count, clr has priority over en.
module wm_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (!reset_n || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Purpose: loads a per-phase tick budget on timed-phase entry and pulses sig_Time_Out at expiry.
// Latency: pulse is high in the cycle after load edge + DUR*TICK_DIV counted cycles.
// Backpressure: PAUSE or an open lid freezes the count; resuming the frozen phase keeps progress.
module wash_phase_timer
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SOAK_TICKS  = 3,
  parameter int unsigned WASH_TICKS  = 5,
  parameter int unsigned RINSE_TICKS = 4,
  parameter int unsigned SPIN_TICKS  = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  wash_phase_timer_if.slave bus
);

  localparam longint MAX_DUR = (longint'(1) << CNT_W) - 1;

  if (TICK_DIV < 1 || SOAK_TICKS > MAX_DUR || WASH_TICKS > MAX_DUR ||
      RINSE_TICKS > MAX_DUR || SPIN_TICKS > MAX_DUR) begin : g_param_err
    $error("wash_phase_timer: TICK_DIV below 1 or a phase duration exceeds the counter width");
  end

  logic [2:0]       state_q, frozen_q, frozen_d;
  logic [CNT_W-1:0] rem_q, rem_d, load_val;
  logic             act_q, act_d, to_q, to_d;
  logic             change, timed, resume, load, untimed_clr, count_en, tick;

  assign change   = (bus.state != state_q);
  assign timed    = is_timed(bus.state);
  // Only a return from PAUSE to the same unfinished phase keeps the frozen progress.
  assign resume   = change && timed && (state_q == ST_PAUSE) &&
                    (bus.state == frozen_q) && (rem_q != '0);
  assign load     = change && timed && !resume;
  assign untimed_clr = change && ((bus.state == ST_IDLE) || (bus.state == ST_READY) ||
                                  (bus.state == ST_FAULT));
  assign count_en = timed && !change && act_q && bus.sig_Lid_Closed;
  assign load_val = CNT_W'(phase_dur(bus.state, SOAK_TICKS, WASH_TICKS, RINSE_TICKS, SPIN_TICKS));

  wm_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (count_en),
    .clr     (load || untimed_clr),
    .tick    (tick)
  );

  always_comb begin
    rem_d    = rem_q;
    act_d    = act_q;
    frozen_d = frozen_q;
    to_d     = 1'b0;
    if (load) begin
      rem_d    = load_val;
      act_d    = (load_val != '0);
      to_d     = (load_val == '0);
      frozen_d = bus.state;
    end else if (untimed_clr) begin
      rem_d    = '0;
      act_d    = 1'b0;
      frozen_d = ST_IDLE;
    end else if (tick) begin
      if (rem_q > CNT_W'(1)) begin
        rem_d = rem_q - CNT_W'(1);
      end else begin
        rem_d = '0;
        act_d = 1'b0;
        to_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      frozen_q <= ST_IDLE;
      rem_q    <= '0;
      act_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= bus.state;
      frozen_q <= frozen_d;
      rem_q    <= rem_d;
      act_q    <= act_d;
      to_q     <= to_d;
    end
  end

  assign bus.sig_Time_Out = to_q;
  assign bus.remaining    = rem_q;
  assign bus.phase_active = act_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: cycle-budget reference model, directed phase scenarios, random controller.
module tb_wash_phase_timer;

  localparam int TD = 4;
  localparam int CW = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_SOAK = 3'd2, S_WASH = 3'd3,
                         S_RINSE = 3'd4, S_SPIN = 3'd5, S_PAUSE = 3'd6;

  logic clock = 1'b0;
  logic reset_n;
  int   nchecks = 0;
  int   nerrors = 0;
  bit   chk_en = 1'b0;

  wash_phase_timer_if #(.CNT_W(CW)) bus ();

  wash_phase_timer #(.TICK_DIV(TD), .CNT_W(CW), .SOAK_TICKS(3), .WASH_TICKS(5),
                     .RINSE_TICKS(4), .SPIN_TICKS(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference: the phase is a budget of counted clock cycles; ticks left is its ceiling over TD.
  int         dur_tab [8] = '{0, 0, 3, 5, 4, 6, 0, 0};
  int         m_budget = 0;
  bit         m_active = 1'b0;
  bit         m_pulse  = 1'b0;
  logic [2:0] m_prev   = S_IDLE;
  logic [2:0] m_frozen = S_IDLE;

  function automatic bit timed(input logic [2:0] s);
    return s inside {S_SOAK, S_WASH, S_RINSE, S_SPIN};
  endfunction

  always @(posedge clock) begin : model
    int b; bit a; bit p; logic [2:0] f;
    b = m_budget; a = m_active; f = m_frozen; p = 1'b0;
    if (!reset_n) begin
      b = 0; a = 1'b0; f = S_IDLE;
    end else if (bus.state != m_prev) begin
      if (timed(bus.state)) begin
        if (!(m_prev == S_PAUSE && bus.state == f && b > 0)) begin
          b = dur_tab[bus.state] * TD;
          f = bus.state;
          a = (b > 0);
          p = (b == 0);
        end
      end else if (bus.state != S_PAUSE) begin
        b = 0; a = 1'b0; f = S_IDLE;
      end
    end else if (timed(bus.state) && a && bus.sig_Lid_Closed) begin
      b = b - 1;
      if (b == 0) begin
        a = 1'b0;
        p = 1'b1;
      end
    end
    m_budget <= b;
    m_active <= a;
    m_pulse  <= p;
    m_frozen <= f;
    m_prev   <= reset_n ? bus.state : S_IDLE;
  end

  always @(negedge clock) begin : compare
    bit prev_to;
    if (chk_en) begin
      check("time_out", int'(bus.sig_Time_Out), int'(m_pulse));
      check("remaining", int'(bus.remaining), (m_budget + TD - 1) / TD);
      check("phase_active", int'(bus.phase_active), int'(m_active));
      check("single_cycle_pulse", int'(bus.sig_Time_Out && prev_to), 0);
      prev_to = bus.sig_Time_Out;
    end
  end

  // dt counts negedges after the load edge: pulse seen at i means expiry at load edge + i.
  task automatic wait_pulse(input int max, input int lo, input int hi,
                            output int dt, output int rem0);
    dt = -1;
    rem0 = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (i == 0) rem0 = int'(bus.remaining);
      if (bus.sig_Time_Out === 1'b1) begin
        dt = i;
        break;
      end
      bus.sig_Lid_Closed = !(i >= lo && i < hi);
    end
    bus.sig_Lid_Closed = 1'b1;
  endtask

  task automatic hold(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clock);
      if (bus.sig_Time_Out === 1'b1) pulses++;
    end
  endtask

  task automatic go_idle();
    bus.state = S_IDLE;
    @(negedge clock);
  endtask

  logic [2:0] seq [4] = '{S_SOAK, S_WASH, S_RINSE, S_SPIN};
  int         lat [4] = '{12, 20, 16, 24};

  initial begin
    int dt, r0, pc, extra, r;
    logic [2:0] last;
    reset_n = 1'b0;
    bus.state = S_SOAK;
    bus.sig_Lid_Closed = 1'b1;

    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    check("reset_time_out", int'(bus.sig_Time_Out), 0);
    check("reset_remaining", int'(bus.remaining), 0);
    check("reset_phase_active", int'(bus.phase_active), 0);
    reset_n = 1'b1;
    wait_pulse(100, -1, -1, dt, r0);
    check("reset_release_load", r0, 3);
    check("reset_release_latency", dt, 12);
    check("expired_remaining", int'(bus.remaining), 0);

    go_idle();
    pc = 0;
    bus.state = seq[0];
    for (int i = 0; i < 4; i++) begin
      wait_pulse(200, -1, -1, dt, r0);
      check("sequence_latency", dt, lat[i]);
      if (dt >= 0) pc++;
      if (i < 3) bus.state = seq[i + 1];
    end
    hold(30, extra);
    check("sequence_pulse_count", pc + extra, 4);

    go_idle();
    bus.state = S_WASH;
    repeat (8) @(negedge clock);
    bus.state = S_PAUSE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("pause_remaining_held", int'(bus.remaining), 4);
    end
    bus.state = S_WASH;
    wait_pulse(200, -1, -1, dt, r0);
    check("resume_no_reload", r0, 4);
    check("resume_latency", dt, 13);

    go_idle();
    bus.state = S_SPIN;
    wait_pulse(200, 10, 15, dt, r0);
    check("lid_load", r0, 6);
    check("lid_delayed_latency", dt, 29);

    go_idle();
    bus.state = S_RINSE;
    repeat (6) @(negedge clock);
    bus.state = S_IDLE;
    @(negedge clock);
    check("cancel_remaining", int'(bus.remaining), 0);
    check("cancel_phase_active", int'(bus.phase_active), 0);
    hold(20, pc);
    check("cancel_no_pulse", pc, 0);
    bus.state = S_RINSE;
    @(negedge clock);
    check("reenter_reload", int'(bus.remaining), 4);

    go_idle();
    bus.state = S_WASH;
    repeat (20) @(negedge clock);
    check("pre_collision_remaining", int'(bus.remaining), 1);
    bus.state = S_RINSE;
    @(negedge clock);
    check("collision_no_pulse", int'(bus.sig_Time_Out), 0);
    check("collision_reload", int'(bus.remaining), 4);
    // One negedge after the load edge is already consumed, so expiry lands at i = 16 - 1.
    wait_pulse(200, -1, -1, dt, r0);
    check("collision_rinse_latency", dt, 15);
    hold(50, pc);
    check("held_expired_no_repeat", pc, 0);

    last = S_SOAK;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      r = int'($urandom_range(0, 99));
      reset_n = ($urandom_range(0, 399) != 0);
      bus.sig_Lid_Closed = ($urandom_range(0, 7) != 0);
      if (bus.sig_Time_Out === 1'b1 && r < 70)
        bus.state = (bus.state == S_SPIN) ? S_IDLE : bus.state + 3'd1;
      else if (bus.state == S_PAUSE && r < 8)
        bus.state = last;
      else if (r < 3)
        bus.state = 3'($urandom_range(0, 7));
      else if (r < 5)
        bus.state = S_PAUSE;
      if (timed(bus.state)) last = bus.state;
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
- Phase-duration scheduler for the washing-machine Microcontroller FSM.
- Watches the controller's 3-bit state and loads a per-phase duration on entry to each timed phase (SOAK, WASH, RINSE, SPIN).
- Counts down in prescaled ticks and returns a one-cycle sig_Time_Out pulse that drives the controller's phase advance.
- Freezes the count during PAUSE or lid-open, and resumes the frozen phase without reloading.

Parameters:
- TICK_DIV, 4: clock cycles per tick (≥1).
- CNT_W, 8: width of the remaining-tick counter.
- SOAK_TICKS, 3: SOAK duration in ticks.
- WASH_TICKS, 5: WASH duration in ticks.
- RINSE_TICKS, 4: RINSE duration in ticks.
- SPIN_TICKS, 6: SPIN duration in ticks.

Ports:
- clock, input, 1: single system clock, posedge.
- reset_n, input, 1: synchronous, active-low reset, sampled on posedge clock.
- state, input, 3: current controller state.
- sig_Lid_Closed, input, 1: 0 freezes counting.
- sig_Time_Out, output, 1: one-cycle pulse at phase expiry.
- remaining, output, CNT_W: ticks left in the current or frozen phase.
- phase_active, output, 1: 1 while a timed phase is loaded and not yet expired.

Behaviour:
- State encoding (shared):
  - 0 IDLE, 1 READY, 2 SOAK, 3 WASH, 4 RINSE, 5 SPIN, 6 PAUSE, 7 FAULT.
  - Timed states are 2..5.
- Reset (reset_n=0 at posedge): all registers clear.
  - sig_Time_Out=0, remaining=0, phase_active=0.
  - prescaler=0, state_q=IDLE, frozen_phase=IDLE.
  - Reset mid-phase discards all progress.
- Registered state_q holds the previous cycle's state. A change is state != state_q.
- Load: a change into timed state S, except a resume, sets:
  - remaining=DUR(S), prescaler=0, phase_active=1, frozen_phase=S.
- Resume: change PAUSE -> S with S==frozen_phase and remaining!=0. remaining and prescaler are kept and counting continues.
- Untimed entries:
  - Change into IDLE, READY or FAULT: remaining=0, phase_active=0, prescaler=0, frozen_phase=IDLE.
  - Change into PAUSE: all values held.
- Counting applies only when state is timed, state==state_q, phase_active=1 and sig_Lid_Closed=1.
  - prescaler increments each cycle.
  - At TICK_DIV-1 the prescaler wraps to 0 and one tick occurs.
  - On a tick with remaining>1: decrement.
  - On a tick with remaining==1: remaining=0, phase_active=0, sig_Time_Out=1 for exactly the next cycle.
- Latency: with load at edge L, sig_Time_Out is high during the cycle after edge L + DUR*TICK_DIV.
  - Lid-open or PAUSE cycles add 1:1 to this latency.
- Duration 0: a load with DUR=0 sets phase_active=0 and pulses sig_Time_Out in the cycle after the load.
- After expiry, remaining holds 0 with no further pulses until the next load.
  - A controller that stays in the expired state produces no repeat timeout.
- Simultaneous events:
  - A state change in the same cycle as a would-be expiry tick: the load/resume rule wins and no pulse occurs.
  - Lid opening on the expiry cycle: the tick is suppressed.
- PAUSE -> a different timed state: treated as a fresh load.
- Width: the counter saturates at 0 and never wraps. DUR parameters above 2^CNT_W-1 are a parameter error, checked by an elaboration-time assertion.
- sig_Time_Out is registered and never high for two consecutive cycles.

Decomposition:
- Package wm_pkg holds:
  - the 3-bit state localparams ST_IDLE .. ST_FAULT;
  - function is_timed(state);
  - function phase_dur(state) mapping to the *_TICKS parameters.
- The Microcontroller FSM shares wm_pkg.
- One sub-module, wm_prescaler: TICK_DIV counter with enable and clear inputs and a tick output.

Test Plan:
All scenarios use TICK_DIV=4 and the default durations.
- Reset: reset_n=0 for 2 cycles with state=SOAK -> sig_Time_Out=0, remaining=0, phase_active=0. Release -> load remaining=3; pulse 12 cycles after the load edge.
- Full sequence: state steps SOAK -> WASH -> RINSE -> SPIN, each advanced on sig_Time_Out -> pulses at 12/20/16/24 cycles after each load, exactly 4 single-cycle pulses.
- Pause/resume: WASH, 7 cycles elapsed, PAUSE for 10 cycles, back to WASH -> remaining=4 held during PAUSE; pulse 13 cycles after resume, no reload.
- Lid open: SPIN, sig_Lid_Closed=0 for 5 cycles mid-phase -> remaining frozen; expiry delayed by exactly 5 cycles.
- Cancel: RINSE, then IDLE before expiry -> remaining=0, phase_active=0, no pulse. Re-entering RINSE reloads remaining=4.
- Collision: state changes WASH -> RINSE on the expiry-tick cycle -> no pulse, remaining=4. Also confirm a held expired state gives no second pulse over 50 cycles.
